// File: rtl/fwd_pkg.sv
// Shared types and constants for the LEGv8 forwarding / load-use hazard unit.
// Optional post-WB forwarding is enabled by defining FWD_WB3_EN.
package fwd_pkg;

    localparam int unsigned REG_W = 5;
    localparam logic [REG_W-1:0] XZR = 5'd31;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10,
        FWD_WB3 = 2'b11
    } fwd_sel_t;

    typedef struct packed {
        logic             valid;
        logic [REG_W-1:0] rd;
        logic             regwrite;
        logic             memread;
    } stage_tag_t;

    typedef enum logic {
        RUN,
        STALL
    } state_t;

    // A stage can source forwarding only if it holds a real register-writing producer.
    function automatic logic tag_hit(stage_tag_t tag, logic [REG_W-1:0] rs);
        return tag.valid && tag.regwrite && (tag.rd == rs) && (rs != XZR);
    endfunction

endpackage

// File: rtl/fwd_match.sv
// Per-operand forwarding select: youngest matching producer wins.
// With FWD_WB3_EN defined, the WB-stage tag is also checked and yields FWD_WB3.
module fwd_match
    import fwd_pkg::*;
(
    input  logic [REG_W-1:0] rs_i,
    input  stage_tag_t       ex_i,
    input  stage_tag_t       mem_i,
`ifdef FWD_WB3_EN
    input  stage_tag_t       wb_i,
`endif
    output fwd_sel_t         sel_o
);

    always_comb begin
        sel_o = FWD_RF;
        if (tag_hit(ex_i, rs_i)) begin
            sel_o = FWD_MEM;
        end else if (tag_hit(mem_i, rs_i)) begin
            sel_o = FWD_WB;
`ifdef FWD_WB3_EN
        end else if (tag_hit(wb_i, rs_i)) begin
            sel_o = FWD_WB3;
`endif
        end
    end

    logic unused_memread;
    assign unused_memread = ex_i.memread ^ mem_i.memread;

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and load-use hazard controller: EX/MEM/WB destination shadows,
// registered EX operand selects and a one-bubble load-use stall. Macro: FWD_WB3_EN.
module fwd_hazard_unit
    import fwd_pkg::*;
#(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [REG_W-1:0] id_rn_i,
    input  logic [REG_W-1:0] id_rm_i,
    input  logic [REG_W-1:0] id_rd_i,
    input  logic             id_regwrite_i,
    input  logic             id_memread_i,
    input  logic             flush_i,
    output logic             stall_o,
    output logic             ex_valid_o,
    output logic [1:0]       fwd_a_o,
    output logic [1:0]       fwd_b_o,
    output logic [CNT_W-1:0] stall_count_o
);

    stage_tag_t       ex_q, ex_d, mem_q, wb_q;
    fwd_sel_t         fwd_a_q, fwd_a_d, fwd_b_q, fwd_b_d;
    fwd_sel_t         sel_a, sel_b;
    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             hazard;

    fwd_match u_match_a (
        .rs_i  (id_rn_i),
        .ex_i  (ex_q),
        .mem_i (mem_q),
`ifdef FWD_WB3_EN
        .wb_i  (wb_q),
`endif
        .sel_o (sel_a)
    );

    fwd_match u_match_b (
        .rs_i  (id_rm_i),
        .ex_i  (ex_q),
        .mem_i (mem_q),
`ifdef FWD_WB3_EN
        .wb_i  (wb_q),
`endif
        .sel_o (sel_b)
    );

    // Loads resolve in MEM, so a consumer directly behind a load needs one bubble.
    always_comb begin
        hazard = (state_q == RUN) && id_valid_i && ex_q.valid && ex_q.memread &&
                 (ex_q.rd != XZR) && ((ex_q.rd == id_rn_i) || (ex_q.rd == id_rm_i));
        stall_o = hazard && !flush_i;
    end

    always_comb begin
        ex_d    = '0;
        fwd_a_d = FWD_RF;
        fwd_b_d = FWD_RF;
        state_d = RUN;
        cnt_d   = cnt_q;
        if (flush_i) begin
            state_d = RUN;
        end else if (hazard) begin
            state_d = STALL;
            if (cnt_q != '1) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end else if (id_valid_i) begin
            ex_d.valid    = 1'b1;
            ex_d.rd       = id_rd_i;
            ex_d.regwrite = id_regwrite_i;
            ex_d.memread  = id_memread_i;
            fwd_a_d       = sel_a;
            fwd_b_d       = sel_b;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ex_q    <= '0;
            mem_q   <= '0;
            wb_q    <= '0;
            fwd_a_q <= FWD_RF;
            fwd_b_q <= FWD_RF;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            mem_q   <= ex_q;
            wb_q    <= mem_q;
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign ex_valid_o    = ex_q.valid;
    assign fwd_a_o       = fwd_a_q;
    assign fwd_b_o       = fwd_b_q;
    assign stall_count_o = cnt_q;

    // The WB shadow only feeds the post-WB select; its load flag is never needed.
    logic unused_wb;
    assign unused_wb = ^wb_q;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: the driver queues hand-computed expectations,
// a monitor pops one per cycle and compares stall (pre-edge) and registered outputs.
module tb_fwd_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        id_valid = 1'b0;
    logic [4:0]  id_rn = '0, id_rm = '0, id_rd = '0;
    logic        id_regwrite = 1'b0, id_memread = 1'b0, flush = 1'b0;
    logic        stall_o, ex_valid_o;
    logic [1:0]  fwd_a_o, fwd_b_o;
    logic [15:0] stall_count_o;

    typedef struct {
        string       name;
        logic        stall;
        logic        exv;
        logic [1:0]  a;
        logic [1:0]  b;
        logic [15:0] cnt;
    } exp_t;

    exp_t sbq[$];
    int   n_tests = 0;
    int   n_fail = 0;

`ifdef FWD_WB3_EN
    localparam logic [1:0] WB3_SEL = 2'b11;
`else
    localparam logic [1:0] WB3_SEL = 2'b00;
`endif

    always #5 clk = ~clk;

    fwd_hazard_unit #(.CNT_W(16)) dut (
        .clk_i         (clk),
        .rst_ni        (rst_n),
        .id_valid_i    (id_valid),
        .id_rn_i       (id_rn),
        .id_rm_i       (id_rm),
        .id_rd_i       (id_rd),
        .id_regwrite_i (id_regwrite),
        .id_memread_i  (id_memread),
        .flush_i       (flush),
        .stall_o       (stall_o),
        .ex_valid_o    (ex_valid_o),
        .fwd_a_o       (fwd_a_o),
        .fwd_b_o       (fwd_b_o),
        .stall_count_o (stall_count_o)
    );

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Drive one ID slot at the negedge; expectations are the stall seen this cycle
    // and the registered outputs after the following rising edge.
    task automatic step(input string nm, input logic v, input logic [4:0] rn, input logic [4:0] rm,
                        input logic [4:0] rd, input logic rw, input logic mr, input logic fl,
                        input logic es, input logic ev, input logic [1:0] ea,
                        input logic [1:0] eb, input logic [15:0] ec);
        @(negedge clk);
        id_valid    = v;
        id_rn       = rn;
        id_rm       = rm;
        id_rd       = rd;
        id_regwrite = rw;
        id_memread  = mr;
        flush       = fl;
        sbq.push_back('{name: nm, stall: es, exv: ev, a: ea, b: eb, cnt: ec});
    endtask

    task automatic nop(input string nm, input logic [15:0] ec);
        step(nm, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 2'b00, ec);
    endtask

    initial begin : monitor
        logic s;
        exp_t e;
        forever begin
            @(negedge clk);
            #2;
            s = stall_o;
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                chk({e.name, ".stall"}, {15'b0, s}, {15'b0, e.stall});
                chk({e.name, ".ex_valid"}, {15'b0, ex_valid_o}, {15'b0, e.exv});
                chk({e.name, ".fwd_a"}, {14'b0, fwd_a_o}, {14'b0, e.a});
                chk({e.name, ".fwd_b"}, {14'b0, fwd_b_o}, {14'b0, e.b});
                chk({e.name, ".count"}, stall_count_o, e.cnt);
            end
        end
    end

    initial begin : driver
        repeat (2) @(negedge clk);
        chk("reset.stall", {15'b0, stall_o}, 16'd0);
        chk("reset.ex_valid", {15'b0, ex_valid_o}, 16'd0);
        chk("reset.fwd_a", {14'b0, fwd_a_o}, 16'd0);
        chk("reset.fwd_b", {14'b0, fwd_b_o}, 16'd0);
        chk("reset.count", stall_count_o, 16'd0);
        rst_n = 1'b1;

        // name, v, rn, rm, rd, rw, mr, fl | stall, ex_valid, fwd_a, fwd_b, count
        step("add_x1",     1, 5'd2,  5'd3,  5'd1,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        step("sub_ex_fwd", 1, 5'd1,  5'd3,  5'd2,  1, 0, 0, 0, 1, 2'b10, 2'b00, 16'd0);
        nop("nop_c3", 16'd0);
        step("add_x1_b",   1, 5'd7,  5'd8,  5'd1,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        nop("nop_c5", 16'd0);
        step("orr_wb_fwd", 1, 5'd1,  5'd1,  5'd4,  1, 0, 0, 0, 1, 2'b01, 2'b01, 16'd0);
        step("add_x9",     1, 5'd4,  5'd4,  5'd9,  1, 0, 0, 0, 1, 2'b10, 2'b10, 16'd0);
        step("sub_prio",   1, 5'd4,  5'd9,  5'd10, 1, 0, 0, 0, 1, 2'b01, 2'b10, 16'd0);
        nop("nop_c9", 16'd0);
        nop("nop_c10", 16'd0);

        step("add_xzr",    1, 5'd1,  5'd2,  5'd31, 1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        step("rd_xzr",     1, 5'd31, 5'd31, 5'd3,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        step("ldur_xzr",   1, 5'd1,  5'd0,  5'd31, 1, 1, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        step("use_xzr",    1, 5'd31, 5'd0,  5'd5,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        nop("nop_c15", 16'd0);
        nop("nop_c16", 16'd0);

        step("ldur_x5",    1, 5'd2,  5'd0,  5'd5,  1, 1, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        step("lu_stall",   1, 5'd5,  5'd7,  5'd6,  1, 0, 0, 1, 0, 2'b00, 2'b00, 16'd1);
        step("lu_resume",  1, 5'd5,  5'd7,  5'd6,  1, 0, 0, 0, 1, 2'b01, 2'b00, 16'd1);
        nop("nop_c20", 16'd1);

        step("ldur_x8",    1, 5'd2,  5'd0,  5'd8,  1, 1, 0, 0, 1, 2'b00, 2'b00, 16'd1);
        step("lu_flush",   1, 5'd8,  5'd8,  5'd9,  1, 0, 1, 0, 0, 2'b00, 2'b00, 16'd1);
        nop("nop_c23", 16'd1);
        step("ldur_x8_b",  1, 5'd2,  5'd0,  5'd8,  1, 1, 0, 0, 1, 2'b00, 2'b00, 16'd1);
        step("lu_stall_b", 1, 5'd8,  5'd8,  5'd9,  1, 0, 0, 1, 0, 2'b00, 2'b00, 16'd2);

        // Now in the stall cycle: apply asynchronous reset with hazard-shaped ID inputs.
        @(negedge clk);
        flush = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst.stall", {15'b0, stall_o}, 16'd0);
        chk("midrst.ex_valid", {15'b0, ex_valid_o}, 16'd0);
        chk("midrst.fwd_a", {14'b0, fwd_a_o}, 16'd0);
        chk("midrst.fwd_b", {14'b0, fwd_b_o}, 16'd0);
        chk("midrst.count", stall_count_o, 16'd0);
        id_valid = 1'b0;
        #1;
        rst_n = 1'b1;

        step("post_rst",   1, 5'd8,  5'd8,  5'd9,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        nop("nop_c27", 16'd0);
        nop("nop_c28", 16'd0);
        nop("nop_c29", 16'd0);
        step("add_x1_c",   1, 5'd7,  5'd8,  5'd1,  1, 0, 0, 0, 1, 2'b00, 2'b00, 16'd0);
        nop("nop_c31", 16'd0);
        nop("nop_c32", 16'd0);
        step("and_wb3",    1, 5'd1,  5'd1,  5'd2,  1, 0, 0, 0, 1, WB3_SEL, WB3_SEL, 16'd0);
        nop("nop_tail", 16'd0);

        for (int i = 0; i < 8 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        n_tests++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL drain: got %0d pending expected 0", sbq.size());
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
